// File: rtl/emmk_mem_bridge.sv
// emmk_mem_bridge: byte-serial bridge from the core load/store/fetch port to the uio pins
module emmk_mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  bus_out,
  output logic [7:0]  bus_oe,
  input  logic [7:0]  bus_in,
  output logic        bus_req,
  input  logic        bus_ack
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, TURN, RDATA, RESP} state_t;
  state_t state, nxt;
  logic we, err, drive, active, xfer, last, expire;
  logic [3:0] be;
  logic [31:0] addr, wdata, rdata, sel;
  logic [1:0] idx;
  logic [CW-1:0] cnt;
  assign drive = state inside {CMD, ADDR, WDATA};
  assign active = drive || state == RDATA;
  assign xfer = active && bus_ack;
  assign last = idx == 2'd3;
  assign expire = TIMEOUT != 0 && active && !bus_ack && cnt == CW'(TIMEOUT - 1);
  assign req_ready = state == IDLE && !rst;
  assign sel = state == ADDR ? addr : wdata;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req_valid ? CMD : IDLE;
      CMD:     nxt = xfer ? ADDR : CMD;
      ADDR:    nxt = xfer && last ? (we ? WDATA : TURN) : ADDR;
      WDATA:   nxt = xfer && last ? RESP : WDATA;
      TURN:    nxt = RDATA;
      RDATA:   nxt = xfer && last ? RESP : RDATA;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (expire) nxt = RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      we <= 1'b0;
      be <= 4'h0;
      addr <= 32'h0;
      wdata <= 32'h0;
      rdata <= 32'h0;
      idx <= 2'd0;
      cnt <= '0;
      err <= 1'b0;
    end else if (state == IDLE) begin
      rdata <= 32'h0;
      idx <= 2'd0;
      cnt <= '0;
      err <= 1'b0;
      if (req_valid) begin
        we <= req_we;
        be <= req_be;
        addr <= req_addr;
        wdata <= req_wdata;
      end
    end else begin
      idx <= idx + 2'(xfer && state != CMD);
      cnt <= xfer ? '0 : active ? cnt + CW'(1) : cnt;
      if (expire) err <= 1'b1;
      if (state == RDATA && bus_ack) rdata <= {rdata[23:0], bus_in};
    end
  end
  always_comb begin
    bus_oe = drive ? 8'hFF : 8'h00;
    bus_req = active;
    bus_out = !drive ? 8'h00 : state == CMD ? {we, 3'b000, be} : sel[{~idx, 3'b000} +: 8];
    rsp_valid = state == RESP;
    rsp_err = rsp_valid && err;
    rsp_rdata = rsp_valid && !we && !err ? rdata : 32'h0;
  end
endmodule

// File: tb/tb_emmk_mem_bridge.sv
// tb_emmk_mem_bridge: scoreboard bench for the byte-serial memory bridge
module tb_emmk_mem_bridge;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0;
  logic [3:0] req_be = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err, bus_req, bus_ack;
  logic [31:0] rsp_rdata;
  logic [7:0] bus_out, bus_oe;
  logic [7:0] bus_in = 8'h00;
  int tests = 0, fails = 0, cyc = 0, wait_n = 0, w = 0, acks_left = 1000000;
  logic xfer_n = 0, req_n = 0, rdx_n = 0;
  logic [7:0] byte_q[$], rd_q[$];
  typedef struct {int cyc; logic err; logic [31:0] rdata;} rsp_t;
  rsp_t rsp_q[$];
  rsp_t mon_r;
  emmk_mem_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .bus_out(bus_out), .bus_oe(bus_oe),
    .bus_in(bus_in), .bus_req(bus_req), .bus_ack(bus_ack)
  );
  always #5 clk = ~clk;
  assign bus_ack = bus_req && acks_left > 0 && w >= wait_n;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    #1;
    if (xfer_n) begin
      w = 0;
      if (acks_left > 0) acks_left--;
    end else if (req_n) w++;
    if (rdx_n && rd_q.size() != 0) void'(rd_q.pop_front());
    bus_in = rd_q.size() != 0 ? rd_q[0] : 8'h00;
  end
  always @(negedge clk) begin
    xfer_n = bus_req && bus_ack;
    req_n = bus_req;
    rdx_n = bus_req && bus_ack && bus_oe == 8'h00;
    if (bus_req && bus_oe == 8'hFF) begin
      if (byte_q.size() == 0) begin
        if (bus_ack) begin
          tests++;
          fails++;
          $display("FAIL byte: unexpected transfer of %02h at cycle %0d", bus_out, cyc);
        end
      end else if (bus_ack) check("byte", bus_out, byte_q.pop_front());
      else check("hold", bus_out, byte_q[0]);
    end else if (bus_req) check("rd_bus_idle", {bus_oe, bus_out}, 16'h0);
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp: unexpected rsp_valid err=%0b rdata=%0h at cycle %0d", rsp_err, rsp_rdata, cyc);
      end else begin
        mon_r = rsp_q.pop_front();
        check("rsp_cycle", cyc, mon_r.cyc);
        check("rsp_err", rsp_err, mon_r.err);
        check("rsp_rdata", rsp_rdata, mon_r.rdata);
      end
    end
  end
  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int lat, input logic err, input int nbytes, output int acc);
    logic [7:0] b[9];
    b[0] = {we, 3'b000, be};
    for (int i = 0; i < 4; i++) begin
      b[1 + i] = a[8 * (3 - i) +: 8];
      b[5 + i] = wd[8 * (3 - i) +: 8];
    end
    for (int i = 0; i < nbytes; i++) byte_q.push_back(b[i]);
    if (!we) for (int i = 0; i < 4; i++) rd_q.push_back(rd[8 * (3 - i) +: 8]);
    req_we = we;
    req_be = be;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1;
    acc = -1;
    for (int k = 0; k < 200 && acc < 0; k++) begin
      if (req_ready) acc = cyc;
      @(negedge clk);
    end
    if (acc < 0) begin
      tests++;
      fails++;
      $display("FAIL accept: request not accepted within 200 cycles");
    end else if (lat >= 0) rsp_q.push_back('{acc + lat, err, (we || err) ? 32'h0 : rd});
  endtask
  initial begin
    int a1, a2;
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_outs", {rsp_valid, rsp_err, rsp_rdata, bus_out, bus_oe, bus_req}, 0);
    rst = 0;
    #1 check("ready_after_rst", req_ready, 1);
    @(negedge clk);
    issue(1, 4'hF, 32'h0000_1004, 32'hDEADBEEF, 0, 10, 0, 9, a1);
    req_valid = 0;
    repeat (15) @(negedge clk);
    issue(0, 4'h3, 32'h0000_0020, 0, 32'h12345678, 11, 0, 5, a1);
    req_valid = 0;
    repeat (15) @(negedge clk);
    wait_n = 3;
    issue(1, 4'hA, 32'hCAFE_0010, 32'h01020304, 0, 37, 0, 9, a1);
    req_valid = 0;
    repeat (45) @(negedge clk);
    issue(0, 4'h5, 32'h0000_0100, 0, 32'h89ABCDEF, 38, 0, 5, a1);
    req_valid = 0;
    repeat (45) @(negedge clk);
    wait_n = 0;
    acks_left = 3;
    issue(1, 4'hF, 32'hA1B2_C3D4, 32'h55667788, 0, 8, 1, 3, a1);
    req_valid = 0;
    repeat (8) @(negedge clk);
    check("timeout_ready", {req_ready, bus_req}, 2'b10);
    acks_left = 1000000;
    repeat (3) @(negedge clk);
    issue(1, 4'hF, 32'h0000_0040, 32'h11223344, 0, -1, 0, 9, a1);
    req_valid = 0;
    repeat (6) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("mid_rst_bus", {bus_req, bus_oe, bus_out, rsp_valid}, 0);
    rst = 0;
    byte_q.delete();
    #1 check("mid_rst_ready", req_ready, 1);
    @(negedge clk);
    issue(0, 4'hC, 32'h0000_0044, 0, 32'hA5A55A5A, 11, 0, 5, a1);
    req_valid = 0;
    repeat (15) @(negedge clk);
    issue(0, 4'h1, 32'h0000_0080, 0, 32'h0BADF00D, 11, 0, 5, a1);
    issue(1, 4'h8, 32'h0000_0084, 32'hFEEDFACE, 0, 10, 0, 9, a2);
    req_valid = 0;
    check("b2b_accept", a2, a1 + 12);
    repeat (15) @(negedge clk);
    check("drain", byte_q.size() + rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
